// File: rtl/kws_host_link.sv
// Host link for the keyword-spotting core: serialises host words onto the core's load pins,
// starts the core, then deserialises its serial result into a host-facing valid/ready word.
module kws_host_link #(
  parameter int unsigned WORD_W    = 64,
  parameter int unsigned NUM_WORDS = 4,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              kws_serial_data_in,
  output logic              kws_serial_load_enable,
  output logic              kws_start_computation,
  input  logic              kws_serial_data_out,
  input  logic              kws_computation_done,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WORD_W-1:0] res_data,
  output logic              busy,
  output logic              timeout_err
);

  localparam int unsigned BitW = $clog2(WORD_W);
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StNext, StStart, StWaitDone, StCapture, StResult
  } state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] load_sr_q, load_sr_d;
  logic [WORD_W-1:0] res_q, res_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]        word_cnt_q, word_cnt_d;
  logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic              done_prev_q;
  logic              in_ready_q, in_ready_d;
  logic              sdi_q, sdi_d;
  logic              load_en_q, load_en_d;
  logic              start_q, start_d;
  logic              res_valid_q, res_valid_d;
  logic              busy_q, busy_d;
  logic              tmo_err_q, tmo_err_d;
  logic              done_rise;
  logic [8:0]        word_inc;
  logic              last_word;

  assign done_rise = kws_computation_done & ~done_prev_q;
  // Nine bits so the compare against NUM_WORDS happens before the counter could wrap.
  assign word_inc  = {1'b0, word_cnt_q} + 9'd1;
  assign last_word = (word_inc == 9'(NUM_WORDS));

  always_comb begin
    state_d     = state_q;
    load_sr_d   = load_sr_q;
    res_d       = res_q;
    bit_cnt_d   = bit_cnt_q;
    word_cnt_d  = word_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    sdi_d       = 1'b0;
    load_en_d   = 1'b0;
    start_d     = 1'b0;
    res_valid_d = res_valid_q;
    tmo_err_d   = tmo_err_q;

    unique case (state_q)
      StIdle, StNext: begin
        // in_ready_q gates the accept so the first cycle after reset release is not an accept.
        if (in_valid && in_ready_q) begin
          sdi_d     = in_data[WORD_W-1];
          load_sr_d = {in_data[WORD_W-2:0], 1'b0};
          load_en_d = 1'b1;
          bit_cnt_d = '0;
          state_d   = StLoad;
          if (state_q == StIdle) begin
            tmo_err_d  = 1'b0;
            word_cnt_d = '0;
          end
        end
      end
      StLoad: begin
        if (bit_cnt_q == BitW'(WORD_W - 1)) begin
          word_cnt_d = word_inc[7:0];
          start_d    = last_word;
          state_d    = last_word ? StStart : StNext;
        end else begin
          bit_cnt_d = bit_cnt_q + BitW'(1);
          sdi_d     = load_sr_q[WORD_W-1];
          load_sr_d = {load_sr_q[WORD_W-2:0], 1'b0};
          load_en_d = 1'b1;
        end
      end
      StStart: begin
        tmo_cnt_d = '0;
        state_d   = StWaitDone;
      end
      StWaitDone: begin
        if (done_rise) begin
          res_d     = {res_q[WORD_W-2:0], kws_serial_data_out};
          bit_cnt_d = '0;
          state_d   = StCapture;
        end else if (tmo_cnt_q == TmoW'(TIMEOUT - 1)) begin
          tmo_err_d = 1'b1;
          state_d   = StIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        end
      end
      StCapture: begin
        res_d = {res_q[WORD_W-2:0], kws_serial_data_out};
        if (bit_cnt_q == BitW'(WORD_W - 2)) begin
          res_valid_d = 1'b1;
          state_d     = StResult;
        end else begin
          bit_cnt_d = bit_cnt_q + BitW'(1);
        end
      end
      StResult: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    in_ready_d = (state_d == StIdle) || (state_d == StNext);
    busy_d     = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      load_sr_q   <= '0;
      res_q       <= '0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      done_prev_q <= 1'b0;
      in_ready_q  <= 1'b0;
      sdi_q       <= 1'b0;
      load_en_q   <= 1'b0;
      start_q     <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      tmo_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_sr_q   <= load_sr_d;
      res_q       <= res_d;
      bit_cnt_q   <= bit_cnt_d;
      word_cnt_q  <= word_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      done_prev_q <= kws_computation_done;
      in_ready_q  <= in_ready_d;
      sdi_q       <= sdi_d;
      load_en_q   <= load_en_d;
      start_q     <= start_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      tmo_err_q   <= tmo_err_d;
    end
  end

  assign in_ready               = in_ready_q;
  assign kws_serial_data_in     = sdi_q;
  assign kws_serial_load_enable = load_en_q;
  assign kws_start_computation  = start_q;
  assign res_valid              = res_valid_q;
  assign res_data               = res_q;
  assign busy                   = busy_q;
  assign timeout_err            = tmo_err_q;

endmodule

// File: doc/kws_host_link.md
# kws_host_link

Host-side link stage that feeds the keyword-spotting compute core and collects its answer. It accepts 64-bit words from a host valid/ready stream and serialises them MSB-first onto the core's serial load pins. After a fixed number of words it pulses the core's start input, waits for the completion edge and deserialises the core's serial result stream back into a 64-bit word. The result is presented to the host on a valid/ready output.

## Interface
- `WORD_W`, 64: word width; fixed to the core's shift-register width.
- `NUM_WORDS`, 4: words loaded per inference (1..255).
- `TIMEOUT`, 4096: maximum cycles waited for completion after start (≥ 2).

- `clk`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  host word available.
- `in_ready`  out  1  block can accept a host word.
- `in_data`  in  WORD_W  host word.
- `kws_serial_data_in`  out  1  serial load bit to the core.
- `kws_serial_load_enable`  out  1  qualifies `kws_serial_data_in`.
- `kws_start_computation`  out  1  one-cycle start pulse to the core.
- `kws_serial_data_out`  in  1  serial result bit from the core.
- `kws_computation_done`  in  1  core completion level.
- `res_valid`  out  1  result word available.
- `res_ready`  in  1  host accepts the result.
- `res_data`  out  WORD_W  captured result.
- `busy`  out  1  high in every state except IDLE.
- `timeout_err`  out  1  sticky flag: the last inference timed out.

## Operation
- All outputs are registered. While `reset` is low, every output is 0 and the state is IDLE.
- FSM states: IDLE, LOAD, NEXT, START, WAIT_DONE, CAPTURE, RESULT.
- **IDLE / NEXT**
  - `in_ready` is 1.
  - On `in_valid && in_ready`, latch `in_data` into the shift register, clear the bit counter and go to LOAD.
  - An accept in IDLE also clears `timeout_err` and the word counter.
- **LOAD**
  - Runs for exactly 64 cycles with `kws_serial_load_enable` high.
  - `kws_serial_data_in` carries bit 63 first, down to bit 0.
  - After the 64th bit, increment the word counter.
  - If the counter equals `NUM_WORDS`, go to START; otherwise go to NEXT.
- **START**
  - `kws_start_computation` is 1 for exactly one cycle.
  - Then go to WAIT_DONE with the timeout counter cleared.
- **WAIT_DONE**
  - Completion is a rising edge of `kws_computation_done`: it was 0 in the previous cycle and is 1 in this cycle.
  - A level that is already high is not completion.
  - On the edge, sample `kws_serial_data_out` as `res_data[63]` in that same cycle and go to CAPTURE.
  - If `TIMEOUT` cycles pass with no edge, set `timeout_err`, do not set `res_valid`, and go to IDLE.
- **CAPTURE**
  - Sample the next 63 cycles into bits 62..0, in order.
  - Then set `res_valid` and go to RESULT.
- **RESULT**
  - `res_data` and `res_valid` hold stable until `res_ready`.
  - On the handshake cycle, clear `res_valid` and go to IDLE.
- The edge detector's previous-value register resets to 0 and updates every cycle in every state.
- If `reset` asserts mid-operation, the block aborts immediately and returns to IDLE with all outputs 0. Partially loaded or captured data is discarded.
- Inputs `in_valid`/`in_data` are ignored outside IDLE/NEXT. `res_ready` is ignored outside RESULT.

## Timing
- Word accepted at cycle T:
  - load bits appear in cycles T+1..T+64;
  - `in_ready` rises at T+65 (or START follows at T+65 for the last word).
- Back-to-back words with `in_valid` held high: 65 cycles per word.
- After the last load bit at cycle L:
  - `kws_start_computation` is high at L+1;
  - WAIT_DONE starts at L+2.
- Done edge at cycle D: capture occupies D..D+63, and `res_valid` is high from D+64.
- Timeout: WAIT_DONE entered at W with no edge → `timeout_err` high at W+TIMEOUT and state is IDLE at W+TIMEOUT.
- The bit and word counters never wrap within a state. The word counter is compared with `NUM_WORDS` before it could wrap.

## Test plan
- **Reset:** hold `reset` low with random inputs → all outputs 0. Release → `in_ready`=1 on the first edge, `busy`=0.
- **Single word, `NUM_WORDS`=1:** send 0xA5A5_0000_FFFF_1234 → 64 load cycles, MSB first (first bit 1, last bit 0), then exactly one start pulse. A core model raises done 10 cycles later and streams 0x0123_4567_89AB_CDEF → `res_data`=0x0123_4567_89AB_CDEF, `res_valid` 64 cycles after the edge.
- **Four words, `in_valid` held high:** → 4×64 load-enable cycles, each followed by a one-cycle gap, then one start pulse; `in_ready` low during every LOAD.
- **Backpressure:** `res_ready` held low for 20 cycles → `res_valid` and `res_data` stable throughout. Drop on the `res_ready` cycle; `in_ready` high next cycle.
- **Timeout:** `TIMEOUT`=16, done held high from before start (no edge) → `timeout_err`=1 exactly 16 cycles into WAIT_DONE, no `res_valid`. The next accepted word clears `timeout_err`.
- **Reset mid-CAPTURE:** assert `reset` at bit 30 → outputs 0 immediately. After release, a full new inference returns the correct result.
